fetch_controller: RTL and testbench

Sequencer for the fetch stage of the five-stage pipeline. Owns the program counter, drives the instruction-memory address, assembles one- and two-word instructions, and loads the IF/ID pipeline register. It honours stall requests from the hazard unit and redirect (jump/branch) requests from later stages. It sits between the instruction memory and the decode stage.

---
 rtl/fetch_controller_pkg.sv | 24 ++
 rtl/fetch_controller_if.sv | 56 +++++
 rtl/fetch_controller_pc_unit.sv | 32 +++
 rtl/fetch_controller.sv | 93 +++++++++
 tb/tb_fetch_controller.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the fetch stage: FSM states, instruction field layout
// and reset defaults.
package fetch_controller_pkg;

   localparam int unsigned INSTR_W          = 16;
   localparam int unsigned ADDR_W_DEFAULT   = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

   localparam int unsigned IMM_BIT    = 0;
   localparam int unsigned SHMNT_LSB  = 1;
   localparam int unsigned SHMNT_MSB  = 4;
   localparam int unsigned RD_LSB     = 5;
   localparam int unsigned RD_MSB     = 7;
   localparam int unsigned RS_LSB     = 8;
   localparam int unsigned RS_MSB     = 10;
   localparam int unsigned OPCODE_LSB = 11;
   localparam int unsigned OPCODE_MSB = 15;

   typedef enum logic [0:0] {
      S_FETCH = 1'b0,
      S_IMM   = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and the
// IF/ID register outputs.
interface fetch_controller_if #(
   parameter int unsigned ADDR_W  = fetch_controller_pkg::ADDR_W_DEFAULT,
   parameter int unsigned INSTR_W = fetch_controller_pkg::INSTR_W
);
   logic               stall;
   logic               jump_valid;
   logic [ADDR_W-1:0]  jump_address;
   logic [ADDR_W-1:0]  imem_address;
   logic [INSTR_W-1:0] imem_rdata;
   logic               ifid_valid;
   logic [INSTR_W-1:0] ifid_instr;
   logic [INSTR_W-1:0] ifid_immediate;
   logic [ADDR_W-1:0]  ifid_next_pc;
   logic               ifid_is_immediate;
   logic [3:0]         ifid_shmnt;
   logic [2:0]         ifid_rd;
   logic [2:0]         ifid_rs;
   logic [4:0]         ifid_opcode;

   modport master (
      input  stall,
      input  jump_valid,
      input  jump_address,
      input  imem_rdata,
      output imem_address,
      output ifid_valid,
      output ifid_instr,
      output ifid_immediate,
      output ifid_next_pc,
      output ifid_is_immediate,
      output ifid_shmnt,
      output ifid_rd,
      output ifid_rs,
      output ifid_opcode
   );

   modport slave (
      output stall,
      output jump_valid,
      output jump_address,
      output imem_rdata,
      input  imem_address,
      input  ifid_valid,
      input  ifid_instr,
      input  ifid_immediate,
      input  ifid_next_pc,
      input  ifid_is_immediate,
      input  ifid_shmnt,
      input  ifid_rd,
      input  ifid_rs,
      input  ifid_opcode
   );

endinterface

// File: rtl/fetch_controller_pc_unit.sv
// Program counter: redirect load beats hold, hold beats increment.
module fetch_controller_pc_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              hold,
   input  logic              incr,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus1
);

   logic [ADDR_W-1:0] pc_q;

   // Wraps modulo 2^ADDR_W with no carry out.
   assign pc_plus1 = pc_q + ADDR_W'(1);
   assign pc       = pc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else if (load) begin
         pc_q <= load_addr;
      end else if (!hold && incr) begin
         pc_q <= pc_plus1;
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: owns the PC, assembles one/two-word instructions and
// loads the IF/ID register, honouring stall and redirect requests.
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input logic                clk,
   input logic                rst,
   fetch_controller_if.master bus
);

   fetch_state_e       state_q;
   logic [INSTR_W-1:0] hold_q;
   logic               valid_q;
   logic [INSTR_W-1:0] instr_q;
   logic [INSTR_W-1:0] imm_q;
   logic [ADDR_W-1:0]  next_pc_q;
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  pc_plus1;
   logic [INSTR_W-1:0] word;

   assign word = bus.imem_rdata;

   fetch_controller_pc_unit #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_unit (
      .clk       (clk),
      .rst       (rst),
      .load      (bus.jump_valid),
      .load_addr (bus.jump_address),
      .hold      (bus.stall),
      .incr      (1'b1),
      .pc        (pc),
      .pc_plus1  (pc_plus1)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         hold_q    <= '0;
         valid_q   <= 1'b0;
         instr_q   <= '0;
         imm_q     <= '0;
         next_pc_q <= '0;
      end else if (bus.jump_valid) begin
         // Redirect drops any half-assembled immediate instruction.
         state_q   <= S_FETCH;
         hold_q    <= '0;
         valid_q   <= 1'b0;
         instr_q   <= '0;
         imm_q     <= '0;
         next_pc_q <= '0;
      end else if (!bus.stall) begin
         unique case (state_q)
            S_FETCH: begin
               if (word[IMM_BIT]) begin
                  hold_q  <= word;
                  valid_q <= 1'b0;
                  state_q <= S_IMM;
               end else begin
                  valid_q   <= 1'b1;
                  instr_q   <= word;
                  imm_q     <= '0;
                  next_pc_q <= pc_plus1;
               end
            end
            S_IMM: begin
               valid_q   <= 1'b1;
               instr_q   <= hold_q;
               imm_q     <= word;
               next_pc_q <= pc_plus1;
               state_q   <= S_FETCH;
            end
            default: state_q <= S_FETCH;
         endcase
      end
   end

   assign bus.imem_address      = pc;
   assign bus.ifid_valid        = valid_q;
   assign bus.ifid_instr        = instr_q;
   assign bus.ifid_immediate    = imm_q;
   assign bus.ifid_next_pc      = next_pc_q;
   assign bus.ifid_is_immediate = instr_q[IMM_BIT];
   assign bus.ifid_shmnt        = instr_q[SHMNT_MSB:SHMNT_LSB];
   assign bus.ifid_rd           = instr_q[RD_MSB:RD_LSB];
   assign bus.ifid_rs           = instr_q[RS_MSB:RS_LSB];
   assign bus.ifid_opcode       = instr_q[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: directed program, monitor pops expected
// IF/ID contents whenever a new valid instruction appears.
module tb_fetch_controller;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] imm;
      logic [31:0] next_pc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [15:0] mem [0:255];
   exp_t        exp_q [$];
   exp_t        mon_e;
   logic        edge_stalled;
   int          checks;
   int          errors;

   fetch_controller_if #(.ADDR_W(32), .INSTR_W(16)) bus ();

   fetch_controller #(
      .ADDR_W   (32),
      .RESET_PC (32'h0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.imem_rdata = mem[bus.imem_address[7:0]];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] i, input logic [15:0] im, input logic [31:0] np);
      exp_t e;
      e.instr   = i;
      e.imm     = im;
      e.next_pc = np;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // A held IF/ID register after a stalled edge is not a new instruction.
   always @(posedge clk) edge_stalled = bus.stall && !bus.jump_valid;

   always @(negedge clk) begin
      if (!rst && bus.ifid_valid && !edge_stalled) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got instr %h expected none", bus.ifid_instr);
         end else begin
            mon_e = exp_q.pop_front();
            check("mon_instr", {16'h0, bus.ifid_instr}, {16'h0, mon_e.instr});
            check("mon_immediate", {16'h0, bus.ifid_immediate}, {16'h0, mon_e.imm});
            check("mon_next_pc", bus.ifid_next_pc, mon_e.next_pc);
            check("mon_is_imm", {31'h0, bus.ifid_is_immediate}, {31'h0, mon_e.instr[0]});
            check("mon_shmnt", {28'h0, bus.ifid_shmnt}, {28'h0, mon_e.instr[4:1]});
            check("mon_rd", {29'h0, bus.ifid_rd}, {29'h0, mon_e.instr[7:5]});
            check("mon_rs", {29'h0, bus.ifid_rs}, {29'h0, mon_e.instr[10:8]});
            check("mon_opcode", {27'h0, bus.ifid_opcode}, {27'h0, mon_e.instr[15:11]});
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      edge_stalled = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0;
      mem[0]    = 16'hA0E2;
      mem[1]    = 16'h1002;
      mem[2]    = 16'h2004;
      mem[3]    = 16'h3006;
      mem[4]    = 16'h0801;
      mem[5]    = 16'h1234;
      mem[6]    = 16'h4A0A;
      mem[7]    = 16'h5B0C;
      mem[8]    = 16'h6C0E;
      mem[9]    = 16'h7D10;
      mem[10]   = 16'h0003;
      mem[11]   = 16'hFFFF;
      mem[8'h40] = 16'h8822;
      mem[8'h41] = 16'h9944;
      mem[8'hFF] = 16'hC0E4;

      rst = 1'b1;
      bus.stall = 1'b0;
      bus.jump_valid = 1'b0;
      bus.jump_address = 32'h0;
      repeat (2) @(posedge clk);
      #2;
      check("reset_pc", bus.imem_address, 32'h0);
      check("reset_valid", {31'h0, bus.ifid_valid}, 32'h0);
      check("reset_instr", {16'h0, bus.ifid_instr}, 32'h0);
      check("reset_immediate", {16'h0, bus.ifid_immediate}, 32'h0);
      check("reset_next_pc", bus.ifid_next_pc, 32'h0);
      check("reset_opcode", {27'h0, bus.ifid_opcode}, 32'h0);
      rst = 1'b0;

      // First instruction straight out of reset, fields hand-decoded.
      push(16'hA0E2, 16'h0, 32'h1);
      tick();
      check("first_valid", {31'h0, bus.ifid_valid}, 32'h1);
      check("first_opcode", {27'h0, bus.ifid_opcode}, 32'h14);
      check("first_rs", {29'h0, bus.ifid_rs}, 32'h0);
      check("first_rd", {29'h0, bus.ifid_rd}, 32'h7);
      check("first_shmnt", {28'h0, bus.ifid_shmnt}, 32'h1);
      check("first_next_pc", bus.ifid_next_pc, 32'h1);
      check("first_pc", bus.imem_address, 32'h1);

      push(16'h1002, 16'h0, 32'h2); tick();
      push(16'h2004, 16'h0, 32'h3); tick();
      push(16'h3006, 16'h0, 32'h4); tick();
      check("seq_pc", bus.imem_address, 32'h4);

      // Immediate instruction: bubble edge then assembled output.
      tick();
      check("imm_bubble_valid", {31'h0, bus.ifid_valid}, 32'h0);
      check("imm_bubble_pc", bus.imem_address, 32'h5);
      push(16'h0801, 16'h1234, 32'h6);
      tick();
      check("imm_valid", {31'h0, bus.ifid_valid}, 32'h1);
      check("imm_immediate", {16'h0, bus.ifid_immediate}, 32'h1234);
      check("imm_pc", bus.imem_address, 32'h6);

      push(16'h4A0A, 16'h0, 32'h7); tick();
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_pc", bus.imem_address, 32'h7);
         check("stall_valid", {31'h0, bus.ifid_valid}, 32'h1);
         check("stall_instr", {16'h0, bus.ifid_instr}, 32'h4A0A);
         check("stall_next_pc", bus.ifid_next_pc, 32'h7);
      end
      bus.stall = 1'b0;
      push(16'h5B0C, 16'h0, 32'h8); tick();
      push(16'h6C0E, 16'h0, 32'h9); tick();
      push(16'h7D10, 16'h0, 32'hA); tick();
      check("resume_pc", bus.imem_address, 32'hA);

      // Redirect while half-way through an immediate instruction, with stall.
      tick();
      check("simm_valid", {31'h0, bus.ifid_valid}, 32'h0);
      check("simm_pc", bus.imem_address, 32'hB);
      bus.jump_valid = 1'b1;
      bus.jump_address = 32'h40;
      bus.stall = 1'b1;
      tick();
      bus.jump_valid = 1'b0;
      bus.stall = 1'b0;
      check("jump_pc", bus.imem_address, 32'h40);
      check("jump_valid_out", {31'h0, bus.ifid_valid}, 32'h0);
      check("jump_instr", {16'h0, bus.ifid_instr}, 32'h0);
      check("jump_next_pc", bus.ifid_next_pc, 32'h0);
      push(16'h8822, 16'h0, 32'h41); tick();
      push(16'h9944, 16'h0, 32'h42); tick();

      // PC wrap from all-ones.
      bus.jump_valid = 1'b1;
      bus.jump_address = 32'hFFFF_FFFF;
      tick();
      bus.jump_valid = 1'b0;
      check("wrap_start_pc", bus.imem_address, 32'hFFFF_FFFF);
      push(16'hC0E4, 16'h0, 32'h0); tick();
      check("wrap_pc", bus.imem_address, 32'h0);
      check("wrap_next_pc", bus.ifid_next_pc, 32'h0);

      push(16'hA0E2, 16'h0, 32'h1); tick();
      push(16'h1002, 16'h0, 32'h2); tick();
      push(16'h2004, 16'h0, 32'h3); tick();
      push(16'h3006, 16'h0, 32'h4); tick();
      tick();
      check("pre_rst_state_pc", bus.imem_address, 32'h5);

      // Asynchronous reset between edges while in S_IMM.
      #1 rst = 1'b1;
      #1;
      check("async_rst_pc", bus.imem_address, 32'h0);
      check("async_rst_valid", {31'h0, bus.ifid_valid}, 32'h0);
      check("async_rst_instr", {16'h0, bus.ifid_instr}, 32'h0);
      check("async_rst_next_pc", bus.ifid_next_pc, 32'h0);
      @(negedge clk);
      #1 rst = 1'b0;
      push(16'hA0E2, 16'h0, 32'h1); tick();
      check("post_rst_pc", bus.imem_address, 32'h1);
      push(16'h1002, 16'h0, 32'h2); tick();

      @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
